// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with enable. A start loads load_val and enters RUN;
//   each enabled cycle decrements the count. When the count leaves 1 a
//   one-cycle done pulse is emitted and the timer either stops (one-shot) or
//   reloads the value captured at start (periodic tick).
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      load load_val and begin counting
//   stop      in   1      abort counting, hold current count (wins over start)
//   en        in   1      decrement enable while running
//   reload    in   1      1 = auto-reload on expiry, 0 = one-shot
//   load_val  in   WIDTH  start / reload value, captured when start is taken
//   count     out  WIDTH  current counter value (registered)
//   busy      out  1      high while in RUN (registered state)
//   done      out  1      one-cycle expiry pulse (registered)
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] rld_val, rld_nxt;
  logic             done_q, done_nxt;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count_q <= '0;
      rld_val <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      rld_val <= rld_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state / next-data logic. Priority: stop > start > en.
  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    rld_nxt   = rld_val;
    done_nxt  = 1'b0;
    if (stop) begin
      // Abort: count freezes, no done, drop to IDLE (no-op when already idle).
      state_nxt = IDLE;
    end else if (start) begin
      if (load_val != '0) begin
        count_nxt = load_val;
        rld_nxt   = load_val;
        state_nxt = RUN;
      end else begin
        // Zero load expires immediately and never enters RUN.
        count_nxt = '0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
    end else if (state == RUN && en) begin
      if (count_q > WIDTH'(1)) begin
        count_nxt = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        done_nxt = 1'b1;
        if (reload) begin
          count_nxt = rld_val;
        end else begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end else begin
        // Count of 0 in RUN is unreachable (loads are non-zero); fall back
        // to IDLE rather than wrapping.
        state_nxt = IDLE;
      end
    end
  end

  // Outputs: all come straight from registers.
  always_comb begin
    count = count_q;
    busy  = (state == RUN);
    done  = done_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             en;
  logic             reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .reload   (reload),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int c, input int b, input int d);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".busy"},  int'(busy),  b);
    chk({tag, ".done"},  int'(done),  d);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; reload = 1'b0; load_val = '0;

    // 1 Reset held two cycles, then release with no activity
    tick(); tick();
    chk3("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk3("post_reset_idle", 0, 0, 0);

    // 2 One-shot 3,2,1,0
    load_val = 4'd3; reload = 1'b0; en = 1'b1; start = 1'b1;
    tick(); chk3("os_load", 3, 1, 0);
    start = 1'b0;
    tick(); chk3("os_2", 2, 1, 0);
    tick(); chk3("os_1", 1, 1, 0);
    tick(); chk3("os_expire", 0, 0, 1);
    tick(); chk3("os_after", 0, 0, 0);

    // 3 Auto-reload period 2
    load_val = 4'd2; reload = 1'b1; start = 1'b1;
    tick(); chk3("ar_load", 2, 1, 0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk3($sformatf("ar_%0d", i), (i % 2 == 0) ? 1 : 2, 1, (i % 2 == 1) ? 1 : 0);
    end
    stop = 1'b1;
    tick(); chk3("ar_stop", 2, 0, 0);
    stop = 1'b0;

    // 4 Stop / restart
    load_val = 4'd10; reload = 1'b0; start = 1'b1;
    tick(); chk3("sr_load10", 10, 1, 0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk3($sformatf("sr_tick%0d", i), 10 - i, 1, 0);
    end
    stop = 1'b1;
    tick(); chk3("sr_stop", 6, 0, 0);
    stop = 1'b0;
    tick(); chk3("sr_idle_en", 6, 0, 0);
    load_val = 4'd5; start = 1'b1;
    tick(); chk3("sr_start5", 5, 1, 0);
    load_val = 4'd7;
    tick(); chk3("sr_restart_run", 7, 1, 0);
    start = 1'b0;

    // 5 Edges: zero load from RUN
    load_val = 4'd0; start = 1'b1;
    tick(); chk3("zero_load", 0, 0, 1);
    start = 1'b0;
    tick(); chk3("zero_after", 0, 0, 0);

    // Max load with en toggling
    load_val = 4'd15; en = 1'b0; start = 1'b1;
    tick(); chk3("max_load", 15, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      en = 1'b1;
      tick(); chk3($sformatf("max_en%0d", k), 15 - k, (k == 15) ? 0 : 1, (k == 15) ? 1 : 0);
      en = 1'b0;
      tick(); chk3($sformatf("max_hold%0d", k), 15 - k, (k == 15) ? 0 : 1, 0);
    end

    // stop + start on the same edge: stop wins (idle and running)
    en = 1'b1; stop = 1'b1; start = 1'b1; load_val = 4'd5;
    tick(); chk3("ss_idle", 0, 0, 0);
    stop = 1'b0; load_val = 4'd9;
    tick(); chk3("ss_load9", 9, 1, 0);
    stop = 1'b1; load_val = 4'd3;
    tick(); chk3("ss_run", 9, 0, 0);
    stop = 1'b0; start = 1'b0;

    // Reload value 1: done stuck high, count stays 1
    load_val = 4'd1; reload = 1'b1; start = 1'b1;
    tick(); chk3("r1_load", 1, 1, 0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk3($sformatf("r1_%0d", i), 1, 1, 1);
    end
    stop = 1'b1;
    tick(); chk3("r1_stop", 1, 0, 0);
    stop = 1'b0;

    // 6 Async reset mid-run at count 4
    load_val = 4'd8; reload = 1'b0; start = 1'b1;
    tick(); chk3("ar6_load", 8, 1, 0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk3($sformatf("ar6_tick%0d", i), 8 - i, 1, 0);
    end
    #2 rst_n = 1'b0;
    #1 chk3("async_rst", 0, 0, 0);
    tick(); chk3("async_rst_held", 0, 0, 0);
    #2 rst_n = 1'b1;
    tick(); chk3("post_async", 0, 0, 0);
    tick(); chk3("post_async2", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
